// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Holds the FSM state encoding, payload limits and the header pack/unpack helpers.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        PAY,
        PAR
    } state_t;

    localparam int          MAX_PAYLOAD  = 63;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;

    // The header byte carries the payload length in the upper six bits.
    function automatic logic [7:0] pack_header(input logic [5:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

    function automatic logic [5:0] unpack_len(input logic [7:0] hdr);
        return hdr[7:2];
    endfunction

    function automatic logic [1:0] unpack_addr(input logic [7:0] hdr);
        return hdr[1:0];
    endfunction

endpackage

// File: rtl/router_tx_buffer.sv
// Payload store for one packet: single write port, combinational read port.
// Contents are deliberately not reset; every location is written before it is read.
module router_tx_buffer
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [0:MAX_PAYLOAD];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and parity
// to the router, holding the current byte whenever the router asserts busy.
module router_pkt_tx
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done,
    output logic       err_cfg
);

    state_t     state;
    logic [5:0] len_reg;
    logic [5:0] cnt;
    logic [5:0] idx;
    logic [7:0] header;
    logic [7:0] parity;
    logic [7:0] rd_data;
    logic       wr_en;

    assign wr_en     = (state == LOAD) && s_valid;
    assign s_ready   = (state == LOAD);
    assign tx_active = (state != IDLE);

    router_tx_buffer u_buffer (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (cnt),
        .wr_data (s_data),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            len_reg   <= '0;
            cnt       <= '0;
            idx       <= '0;
            header    <= '0;
            parity    <= '0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            err_cfg   <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dest_addr == ADDR_INVALID || payload_len == 6'd0) begin
                            err_cfg <= 1'b1;
                        end else begin
                            len_reg <= payload_len;
                            header  <= pack_header(payload_len, dest_addr);
                            parity  <= pack_header(payload_len, dest_addr);
                            cnt     <= '0;
                            idx     <= '0;
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        parity <= parity ^ s_data;
                        cnt    <= cnt + 6'd1;
                        // Header goes out on the same edge that takes the last byte.
                        if (cnt == len_reg - 6'd1) begin
                            state     <= HDR;
                            data_out  <= header;
                            pkt_valid <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (!busy) begin
                        state    <= PAY;
                        data_out <= rd_data;
                        idx      <= 6'd1;
                    end
                end
                PAY: begin
                    if (!busy) begin
                        if (idx == len_reg) begin
                            state     <= PAR;
                            data_out  <= parity;
                            pkt_valid <= 1'b0;
                        end else begin
                            data_out <= rd_data;
                            idx      <= idx + 6'd1;
                        end
                    end
                end
                PAR: begin
                    if (!busy) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        data_out <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a queue model of the bytes the router
// must see, compared against the outputs on every falling edge.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] payload_len = 6'd0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       busy = 1'b0;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       err_cfg;

    router_pkt_tx dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .dest_addr   (dest_addr),
        .payload_len (payload_len),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .busy        (busy),
        .data_out    (data_out),
        .pkt_valid   (pkt_valid),
        .tx_active   (tx_active),
        .done        (done),
        .err_cfg     (err_cfg)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    logic [7:0] exp_q[$];
    bit         loading  = 1'b0;
    bit         done_exp = 1'b0;
    bit         err_exp  = 1'b0;
    int         seen_bytes = 0;
    int         hold_cnt = 0;
    logic [7:0] hold_val = 8'h00;
    bit         hold_en = 1'b0;
    logic [7:0] model_hdr;
    logic [7:0] model_par;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        bit last;
        last = 1'b0;
        check("s_ready", s_ready, loading);
        check("tx_active", tx_active, loading || (exp_q.size() > 0));
        check("done", done, done_exp);
        check("err_cfg", err_cfg, err_exp);
        if (exp_q.size() > 0) begin
            check("data_out", data_out, exp_q[0]);
            check("pkt_valid", pkt_valid, exp_q.size() > 1);
            if (hold_en && data_out === hold_val) hold_cnt++;
            if (!busy) begin
                void'(exp_q.pop_front());
                seen_bytes++;
                last = (exp_q.size() == 0);
            end
        end else begin
            check("idle_data_out", data_out, 8'h00);
            check("idle_pkt_valid", pkt_valid, 1'b0);
        end
        done_exp = last;
    end

    task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len,
                            input logic [7:0] bytes[$], input bit gaps,
                            input int busy_at, input int busy_n, input int abort_at);
        logic [7:0] pkt[$];
        logic [7:0] par;
        int i;
        int cyc;
        bit tog;
        model_hdr = {len, addr};
        par = model_hdr;
        pkt.push_back(model_hdr);
        foreach (bytes[k]) begin
            par = par ^ bytes[k];
            pkt.push_back(bytes[k]);
        end
        pkt.push_back(par);
        model_par = par;
        seen_bytes = 0;

        start = 1'b1; dest_addr = addr; payload_len = len;
        step();
        start = 1'b0;
        loading = 1'b1;
        i = 0;
        tog = 1'b0;
        while (i < int'(len)) begin
            // A start with an illegal address while loading must be ignored.
            start = (i == 1);
            dest_addr = (i == 1) ? 2'd3 : addr;
            if (gaps && tog) s_valid = 1'b0;
            else begin
                s_valid = 1'b1;
                s_data = bytes[i];
            end
            step();
            if (s_valid) i++;
            tog = ~tog;
        end
        start = 1'b0;
        dest_addr = addr;
        s_valid = 1'b0;
        loading = 1'b0;
        exp_q = pkt;

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            if (cyc == abort_at) begin
                #2 resetn = 1'b0;
                #1;
                check("async_rst_data_out", data_out, 8'h00);
                check("async_rst_pkt_valid", pkt_valid, 1'b0);
                check("async_rst_tx_active", tx_active, 1'b0);
                exp_q.delete();
                done_exp = 1'b0;
                step();
                step();
                resetn = 1'b1;
                step();
                return;
            end
            busy = (cyc >= busy_at) && (cyc < busy_at + busy_n);
            step();
            cyc++;
        end
        busy = 1'b0;
        check("tx_timeout", exp_q.size(), 0);
        exp_q.delete();
        step();
        step();
        $display("packet addr=%0d len=%0d hdr=0x%02h par=0x%02h bytes_seen=%0d", addr, len, model_hdr, model_par, seen_bytes);
    endtask

    task automatic send_bad(input logic [1:0] addr, input logic [5:0] len);
        start = 1'b1; dest_addr = addr; payload_len = len; s_valid = 1'b1;
        step();
        start = 1'b0;
        err_exp = 1'b1;
        step();
        err_exp = 1'b0;
        step();
        s_valid = 1'b0;
        $display("bad config addr=%0d len=%0d", addr, len);
    endtask

    initial begin
        logic [7:0] b[$];

        #1 resetn = 1'b0;
        #1;
        check("rst_data_out", data_out, 8'h00);
        check("rst_pkt_valid", pkt_valid, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_tx_active", tx_active, 1'b0);
        step();
        step();
        resetn = 1'b1;
        step();

        // Basic packet, no stalls.
        b.delete();
        for (int k = 0; k < 5; k++) b.push_back(8'h11 + 8'(k));
        send_pkt(2'd2, 6'd5, b, 1'b0, 0, 0, -1);
        check("pkt1_hdr", model_hdr, 8'h16);
        check("pkt1_par", model_par, 8'h07);
        check("pkt1_count", seen_bytes, 7);

        // Stall for three cycles while payload byte 3 is on the output.
        b.delete();
        for (int k = 0; k < 16; k++) b.push_back(8'h20 + 8'(k));
        hold_val = 8'h23; hold_cnt = 0; hold_en = 1'b1;
        send_pkt(2'd2, 6'd16, b, 1'b0, 4, 3, -1);
        hold_en = 1'b0;
        check("pkt2_hdr", model_hdr, 8'h42);
        check("pkt2_count", seen_bytes, 18);
        check("pkt2_hold", hold_cnt, 4);

        // Gappy input stream.
        b.delete();
        for (int k = 0; k < 14; k++) b.push_back(8'h40 + 8'(k * 5));
        send_pkt(2'd2, 6'd14, b, 1'b1, 0, 0, -1);
        check("pkt3_hdr", model_hdr, 8'h3A);
        check("pkt3_count", seen_bytes, 16);

        send_bad(2'd3, 6'd5);
        send_bad(2'd1, 6'd0);

        // Reset in the middle of the payload, then a fresh packet.
        b.delete();
        for (int k = 0; k < 8; k++) b.push_back(8'h80 + 8'(k));
        send_pkt(2'd1, 6'd8, b, 1'b0, 0, 0, 3);

        b.delete();
        b.push_back(8'hA5); b.push_back(8'h5A); b.push_back(8'hFF);
        send_pkt(2'd1, 6'd3, b, 1'b0, 0, 0, -1);
        check("pkt5_hdr", model_hdr, 8'h0D);
        check("pkt5_par", model_par, 8'h0D);
        check("pkt5_count", seen_bytes, 5);

        // Largest legal payload.
        b.delete();
        for (int k = 0; k < 63; k++) b.push_back(8'(k * 3));
        send_pkt(2'd0, 6'd63, b, 1'b0, 10, 2, -1);
        check("pkt6_hdr", model_hdr, 8'hFC);
        check("pkt6_count", seen_bytes, 65);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
